// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing and decode.
// Optional retired-instruction counter enabled by defining INSTRET_CNT_EN.
`timescale 1ns/1ps
module riscv_mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWe,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        regWrite,
  output logic        isALUreg,
  output logic        isJAL,
  output logic        isJALR,
  output logic        isBranch,
  output logic        isLUI,
  output logic        isAUIPC,
  output logic        isLoad,
  output logic        isStore,
  output logic        isShamt,
  output logic [2:0]  funct3,
  output logic [3:0]  aluControl,
  output logic        halt,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  state_t cur, nxt;
  logic [8:0] flags_q;
  logic [2:0] f3_q;
  logic [3:0] alu_q;
  logic req_c, we_c, irw_c, pcw_c, rw_c;
  logic dec_vis;
  logic unused_instr;

  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Flag order: ALUreg, JAL, JALR, Branch, LUI, AUIPC, Load, Store, Shamt.
  function automatic logic [8:0] decode_flags(input logic [31:0] ins);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = ins[6:0];
    f3  = ins[14:12];
    decode_flags = {opc == OP_REG, opc == OP_JAL, opc == OP_JR, opc == OP_BR,
                    opc == OP_LUI, opc == OP_AUI, opc == OP_LD, opc == OP_ST,
                    (opc == OP_IMM) && (f3 == 3'b001 || f3 == 3'b101)};
  endfunction

  function automatic logic is_legal(input logic [6:0] opc);
    is_legal = (opc == OP_REG) || (opc == OP_IMM) || (opc == OP_LD) ||
               (opc == OP_ST)  || (opc == OP_BR)  || (opc == OP_JAL) ||
               (opc == OP_JR)  || (opc == OP_LUI) || (opc == OP_AUI);
  endfunction

  function automatic logic [3:0] alu_sel(input logic [31:0] ins);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = ins[6:0];
    f3  = ins[14:12];
    alu_sel = 4'b0000;
    if (opc == OP_REG || opc == OP_IMM) begin
      case (f3)
        3'b000: alu_sel = (opc == OP_REG && ins[30]) ? 4'b0001 : 4'b0000;
        3'b001: alu_sel = 4'b0010;
        3'b010: alu_sel = 4'b0011;
        3'b011: alu_sel = 4'b0100;
        3'b100: alu_sel = 4'b0101;
        3'b101: alu_sel = ins[30] ? 4'b0111 : 4'b0110;
        3'b110: alu_sel = 4'b1000;
        default: alu_sel = 4'b1001;
      endcase
    end else if (opc == OP_BR) begin
      case (f3[2:1])
        2'b00:   alu_sel = 4'b0001;
        2'b10:   alu_sel = 4'b0011;
        2'b11:   alu_sel = 4'b0100;
        default: alu_sel = 4'b0000;
      endcase
    end
  endfunction

  // Decode is captured once on leaving DECODE; an illegal opcode captures zeros for HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_FETCH;
      flags_q <= '0;
      f3_q    <= '0;
      alu_q   <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        if (is_legal(instr[6:0])) begin
          flags_q <= decode_flags(instr);
          f3_q    <= instr[14:12];
          alu_q   <= alu_sel(instr);
        end else begin
          flags_q <= '0;
          f3_q    <= '0;
          alu_q   <= '0;
        end
      end
    end
  end

  always_comb begin
    nxt   = S_FETCH;
    req_c = 1'b0;
    we_c  = 1'b0;
    irw_c = 1'b0;
    pcw_c = 1'b0;
    rw_c  = 1'b0;
    case (cur)
      S_FETCH: begin
        req_c = 1'b1;
        if (memReady) begin
          irw_c = 1'b1;
          nxt   = S_DECODE;
        end else begin
          nxt = S_FETCH;
        end
      end
      S_DECODE: nxt = is_legal(instr[6:0]) ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (flags_q[2] || flags_q[1]) begin
          nxt = S_MEM;
        end else if (flags_q[5]) begin
          pcw_c = 1'b1;
          nxt   = S_FETCH;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        req_c = 1'b1;
        we_c  = flags_q[1];
        if (!memReady) begin
          nxt = S_MEM;
        end else if (flags_q[1]) begin
          pcw_c = 1'b1;
          nxt   = S_FETCH;
        end else begin
          nxt = S_WB;
        end
      end
      S_WB: begin
        rw_c  = 1'b1;
        pcw_c = 1'b1;
        nxt   = S_FETCH;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
  end

  assign memReq   = req_c & ~reset;
  assign memWe    = we_c  & ~reset;
  assign irWrite  = irw_c & ~reset;
  assign pcWrite  = pcw_c & ~reset;
  assign regWrite = rw_c  & ~reset;

  assign dec_vis = (cur != S_FETCH) && (cur != S_DECODE);
  assign {isALUreg, isJAL, isJALR, isBranch, isLUI, isAUIPC, isLoad, isStore, isShamt} =
         dec_vis ? flags_q : 9'd0;
  assign funct3     = dec_vis ? f3_q  : 3'd0;
  assign aluControl = dec_vis ? alu_q : 4'd0;
  assign halt       = (cur == S_HALT);
  assign state      = cur;

`ifdef INSTRET_CNT_EN
  logic [31:0] instret_q;
  always_ff @(posedge clk) begin
    if (reset) instret_q <= '0;
    else if (pcWrite) instret_q <= instret_q + 32'd1;
  end
  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Randomized self-checking bench for riscv_mc_controller against a per-instruction cycle-trace model.
`timescale 1ns/1ps
module tb_riscv_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        memReady;
  logic        memReq, memWe, irWrite, pcWrite, regWrite;
  logic        isALUreg, isJAL, isJALR, isBranch, isLUI, isAUIPC, isLoad, isStore, isShamt;
  logic [2:0]  funct3;
  logic [3:0]  aluControl;
  logic        halt;
  logic [2:0]  state;
  logic [31:0] instret;

  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2,
                         MEM = 3'd3, WB = 3'd4, HALT = 3'd5;

  riscv_mc_controller dut (
    .clk(clk), .reset(reset), .instr(instr), .memReady(memReady),
    .memReq(memReq), .memWe(memWe), .irWrite(irWrite), .pcWrite(pcWrite),
    .regWrite(regWrite), .isALUreg(isALUreg), .isJAL(isJAL), .isJALR(isJALR),
    .isBranch(isBranch), .isLUI(isLUI), .isAUIPC(isAUIPC), .isLoad(isLoad),
    .isStore(isStore), .isShamt(isShamt), .funct3(funct3), .aluControl(aluControl),
    .halt(halt), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_instret;
  logic [8:0]  e_flags;
  logic [2:0]  e_f3;
  logic [3:0]  e_alu;
  logic        e_legal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-class tables.
  task automatic ref_decode(input logic [31:0] ins);
    logic [3:0] imm_tab [8];
    logic [2:0] f3;
    imm_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    f3 = ins[14:12];
    e_flags = '0;
    e_alu   = 4'd0;
    e_legal = 1'b1;
    case (ins[6:0])
      7'b0110011: begin
        e_flags[8] = 1'b1;
        e_alu = imm_tab[f3];
        if (ins[30] && f3 == 3'd0) e_alu = 4'd1;
        if (ins[30] && f3 == 3'd5) e_alu = 4'd7;
      end
      7'b0010011: begin
        e_flags[0] = (f3 == 3'd1) || (f3 == 3'd5);
        e_alu = imm_tab[f3];
        if (ins[30] && f3 == 3'd5) e_alu = 4'd7;
      end
      7'b1101111: e_flags[7] = 1'b1;
      7'b1100111: e_flags[6] = 1'b1;
      7'b1100011: begin
        e_flags[5] = 1'b1;
        if (f3 == 3'd0 || f3 == 3'd1) e_alu = 4'd1;
        else if (f3 == 3'd4 || f3 == 3'd5) e_alu = 4'd3;
        else if (f3 == 3'd6 || f3 == 3'd7) e_alu = 4'd4;
      end
      7'b0110111: e_flags[4] = 1'b1;
      7'b0010111: e_flags[3] = 1'b1;
      7'b0000011: e_flags[2] = 1'b1;
      7'b0100011: e_flags[1] = 1'b1;
      default:    e_legal = 1'b0;
    endcase
    e_f3 = e_legal ? f3 : 3'd0;
  endtask

  // One clock of the expected trace: drive memReady at negedge, check 1ns later.
  task automatic cyc(input logic [2:0] st, input logic mr, input logic irw, input logic pcw,
                     input logic rw, input logic mreq, input logic mwe);
    logic shown;
    @(negedge clk);
    memReady = mr;
    #1;
    shown = (st == EXEC) || (st == MEM) || (st == WB);
    chk("state", {29'd0, state}, {29'd0, st});
    chk("strobes{req,we,ir,pc,rf}", {27'd0, memReq, memWe, irWrite, pcWrite, regWrite},
        {27'd0, mreq, mwe, irw, pcw, rw});
    chk("halt", {31'd0, halt}, {31'd0, st == HALT});
    chk("flags", {23'd0, isALUreg, isJAL, isJALR, isBranch, isLUI, isAUIPC, isLoad, isStore, isShamt},
        {23'd0, shown ? e_flags : 9'd0});
    chk("funct3", {29'd0, funct3}, {29'd0, shown ? e_f3 : 3'd0});
    chk("aluControl", {28'd0, aluControl}, {28'd0, shown ? e_alu : 4'd0});
`ifdef INSTRET_CNT_EN
    chk("instret", instret, m_instret);
`else
    chk("instret", instret, 32'd0);
`endif
    if (pcw) m_instret = m_instret + 32'd1;
  endtask

  // Whole instruction; memReady is random wherever it must be ignored.
  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm);
    logic br, ld, st;
    instr = ins;
    ref_decode(ins);
    br = e_flags[5];
    ld = e_flags[2];
    st = e_flags[1];
    for (int i = 0; i < wf; i++) cyc(FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(DECODE, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (!e_legal) return;
    cyc(EXEC, 1'($urandom), 1'b0, br, 1'b0, 1'b0, 1'b0);
    if (ld || st) begin
      for (int i = 0; i < wm; i++) cyc(MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, st);
      cyc(MEM, 1'b1, 1'b0, st, 1'b0, 1'b1, st);
    end
    if (!br && !st) cyc(WB, 1'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    memReady = 1'($urandom);
    #1;
    chk("rst_strobes", {27'd0, memReq, memWe, irWrite, pcWrite, regWrite}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_state", {29'd0, state}, {29'd0, FETCH});
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_dec", {20'd0, aluControl, funct3, isALUreg, isLoad, isStore, isBranch, isShamt}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    reset = 1'b0;
    memReady = 1'b0;
    m_instret = 32'd0;
    #1;
    chk("first_memReq", {31'd0, memReq}, 32'd1);
  endtask

  task automatic halt_then_reset(input logic [31:0] ins, input int n);
    run_instr(ins, 0, 0);
    for (int i = 0; i < n; i++) cyc(HALT, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
  endtask

  initial begin
    logic [6:0]  opcs [9];
    logic [31:0] r;
    int          k;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    reset = 1'b1;
    memReady = 1'b0;
    instr = 32'd0;
    m_instret = 32'd0;
    do_reset();

    run_instr(32'h00500093, 0, 0);
    run_instr(32'h40208133, 3, 0);
    run_instr(32'h00112023, 0, 0);
    run_instr(32'h00012183, 0, 0);
    run_instr(32'h00208463, 0, 0);
    halt_then_reset(32'hFFFFFFFF, 20);

    // Reset while a load waits in MEM.
    instr = 32'h00012183;
    ref_decode(instr);
    cyc(FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      k = $urandom_range(0, 20);
      if (k >= 9) k = $urandom_range(0, 8);
      if ($urandom_range(0, 29) == 0) begin
        halt_then_reset({r[31:7], ($urandom_range(0, 1) != 0) ? 7'b0001111 : 7'b1110011},
                        $urandom_range(1, 4));
      end else begin
        run_instr({r[31:7], opcs[k]}, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_mc_controller.md
RISCV_MC_CONTROLLER -- requirements
Module: riscv_mc_controller

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: instr  in  32  current instruction word (instruction-register output).
REQ-004 SHALL have: memReady  in  1  memory completes the current request this cycle.
REQ-005 SHALL have: memReq  out  1  memory request; memWe  out  1  write enable, valid only with memReq.
REQ-006 SHALL have: irWrite, pcWrite, regWrite  out  1 each  instruction-register, PC and register-file write strobes.
REQ-007 SHALL have: isALUreg, isJAL, isJALR, isBranch, isLUI, isAUIPC, isLoad, isStore, isShamt  out  1 each  decoded class flags to the Datapath.
REQ-008 SHALL have: funct3  out  3  instr[14:12]; aluControl  out  4  ALU operation select.
REQ-009 SHALL have: halt  out  1  sticky illegal-opcode stop; state  out  3  current FSM state.
REQ-010 SHALL have: instret  out  32  retired-instruction count (see Configuration).

Function
REQ-011 FSM states SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 go to FETCH next cycle.
REQ-012 FETCH: memReq=1, memWe=0; on memReady, irWrite=1 for that cycle and next state is DECODE; otherwise stay in FETCH.
REQ-013 DECODE: decode instr[6:0]; opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 go to EXEC; any other opcode goes to HALT.
REQ-014 Decoded flags, funct3 and aluControl SHALL be registered at the DECODE->EXEC edge and held stable until the next DECODE; they read 0 during FETCH and DECODE.
REQ-015 aluControl SHALL be ADD=0000, SUB=0001, SLL=0010, SLT=0011, SLTU=0100, XOR=0101, SRL=0110, SRA=0111, OR=1000, AND=1001.
REQ-016 aluControl for OP/OP-IMM SHALL come from funct3, with two exceptions: SUB when OP, funct3=000 and instr[30]=1; SRA when funct3=101 and instr[30]=1.
REQ-017 aluControl for branches: BEQ/BNE=SUB; BLT/BGE=SLT; BLTU/BGEU=SLTU. All other classes use ADD.
REQ-018 isShamt SHALL be 1 only for OP-IMM with funct3 001 or 101.
REQ-019 EXEC transitions:
- Load/store -> MEM.
- Branch -> pcWrite=1, then FETCH.
- All other classes -> WB.
REQ-020 MEM: memReq=1, memWe=isStore; wait for memReady. On memReady, load -> WB; store -> pcWrite=1, then FETCH.
REQ-021 WB: regWrite=1 and pcWrite=1 for exactly one cycle, then FETCH.
REQ-022 Latency with zero-wait memory: ALU/LUI/AUIPC/JAL/JALR 4 cycles, load 5, store 4, branch 3. Each memory wait cycle adds 1.
REQ-023 memReady outside FETCH/MEM SHALL be ignored. memReady in the first memReq cycle SHALL be accepted (zero-wait).
REQ-024 HALT: halt=1, all strobes and memReq 0; HALT is left only by reset.
REQ-025 Strobes (irWrite, pcWrite, regWrite, memReq, memWe) SHALL be combinational from state and registered decode only, never from instr directly outside DECODE.

Reset
REQ-026 When reset=1 at a rising edge: state=FETCH; all registered flags, funct3, aluControl, halt and instret = 0.
REQ-027 While reset=1, memReq, memWe, irWrite, pcWrite and regWrite SHALL be 0. Reset during a pending MEM access abandons it with no write strobe.
REQ-028 The first memReq SHALL appear in the first cycle after reset deasserts.

Configuration
REQ-029 Macro INSTRET_CNT_EN defined: instret increments by 1 on every retirement cycle, i.e. every cycle with pcWrite=1. It wraps from FFFFFFFF to 0.
REQ-030 INSTRET_CNT_EN undefined: instret tied to 0 and no counter register is synthesized.

Verification
REQ-031 Reset, then zero-wait memory, instr=00500093 (addi) -> states 0,1,2,4; regWrite and pcWrite in cycle 4; aluControl=0000; instret=1.
REQ-032 instr=40208133 (sub), memReady delayed 3 cycles in FETCH -> irWrite only in the memReady cycle; aluControl=0001; isALUreg=1; total 7 cycles.
REQ-033 Store 00112023 then load 00012183 -> store: memWe=1 in MEM and no regWrite. Load: memWe=0, then WB with regWrite=1. Latencies 4 and 5.
REQ-034 Branch 00208463 (beq) -> states 0,1,2; pcWrite in EXEC; aluControl=0001; isBranch=1; regWrite never 1.
REQ-035 instr=FFFFFFFF -> HALT after DECODE; halt stays 1 for 20 cycles with memReq=0; reset returns state to FETCH.
REQ-036 Assert reset mid-MEM of a load -> next cycle state=FETCH, no regWrite; with INSTRET_CNT_EN, instret preload near FFFFFFFF wraps to 0.
